// File: rtl/jk_excitation_ctrl.sv
// Drives one cycle of J/K excitation into a bank of master-slave JK flip-flops,
// waits for the pair to settle, then checks the fed-back state against the request.
module jk_excitation_ctrl #(
    parameter int WIDTH      = 4,
    parameter int SETTLE     = 1,
    parameter int USE_TOGGLE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_target,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             done,
    output logic             mismatch,
    output logic [WIDTH-1:0] mismatch_mask,
    output logic [7:0]       err_count
);

    typedef enum logic [1:0] {IDLE, DRIVE, WAIT} state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t           state_q;
    logic             ready_q, done_q, mismatch_q;
    logic [WIDTH-1:0] j_q, k_q, mask_q, target_q;
    logic [7:0]       err_q;
    logic [3:0]       cnt_q;

    logic [WIDTH-1:0] diff_d, j_d, k_d, chk_d;

    // Unchanged bits always hold (J=K=0); only differing bits get excitation.
    always_comb begin
        diff_d = q_fb ^ in_target;
        if (USE_TOGGLE != 0) begin
            j_d = diff_d;
            k_d = diff_d;
        end else begin
            j_d = diff_d & in_target;
            k_d = diff_d & ~in_target;
        end
        chk_d = q_fb ^ target_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ready_q    <= 1'b1;
            j_q        <= '0;
            k_q        <= '0;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
            mask_q     <= '0;
            err_q      <= '0;
            cnt_q      <= '0;
            target_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        target_q <= in_target;
                        j_q      <= j_d;
                        k_q      <= k_d;
                        ready_q  <= 1'b0;
                        state_q  <= DRIVE;
                    end
                end
                DRIVE: begin
                    // Master has sampled J/K at this edge; release them.
                    j_q     <= '0;
                    k_q     <= '0;
                    cnt_q   <= CNT_INIT;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        mask_q     <= chk_d;
                        mismatch_q <= |chk_d;
                        done_q     <= 1'b1;
                        if ((|chk_d) && (err_q != 8'hFF))
                            err_q <= err_q + 8'd1;
                        ready_q    <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready      = ready_q;
    assign j_out         = j_q;
    assign k_out         = k_q;
    assign done          = done_q;
    assign mismatch      = mismatch_q;
    assign mismatch_mask = mask_q;
    assign err_count     = err_q;

endmodule
